lsu_nb: RTL and testbench

//  Non-blocking load/store unit between the EXE stage and the core data bus (cb).

---
 rtl/lsu_nb.sv | 277 +++++++++++++++++++++++++++
 tb/tb_lsu_nb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_nb.sv
// Non-blocking load/store unit between the EXE stage and the core data bus.
// One request is issued at a time. Up to MAX_OT transactions can be in flight.
// Load data is aligned and extended here. Misaligned accesses trap before
// they reach the bus. A load never overtakes an outstanding store.

package lsu_nb_pkg;
  localparam logic [1:0] CB_OKAY = 2'b00;

  // Data fields are sized for the widest core; narrower cores use the low bits.
  typedef struct packed {
    logic        rd_addr_valid;
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_ready;
    logic        wr_addr_valid;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic        wr_data_valid;
    logic [63:0] wr_data;
    logic [7:0]  wr_strobe;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic [1:0]  rd_resp;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic        wr_resp_valid;
    logic [1:0]  wr_resp_error;
  } s_cb_miso_t;
endpackage

module lsu_nb
  import lsu_nb_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OT          = 4,
  parameter int SUPPORT_WR_RESP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [2:0]                req_width_i,
  input  logic [31:0]               req_addr_i,
  input  logic [XLEN-1:0]           req_wdata_i,
  input  logic [4:0]                req_rd_i,
  output logic                      ld_valid_o,
  output logic [XLEN-1:0]           ld_data_o,
  output logic [4:0]                ld_rd_o,
  output s_cb_mosi_t                data_cb_mosi_o,
  input  s_cb_miso_t                data_cb_miso_i,
  output logic                      trap_ld_o,
  output logic                      trap_st_o,
  output logic [31:0]               trap_addr_o,
  output logic [$clog2(MAX_OT):0]   ot_cnt_o
);

  localparam int SW = XLEN / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = $clog2(MAX_OT) + 1;
  localparam int PW = $clog2(MAX_OT);

  typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_t;

  state_t          state;
  logic            lat_store;
  logic [2:0]      lat_width;
  logic [31:0]     lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [4:0]      lat_rd;
  logic            aw_done, w_done;
  logic [CW-1:0]   ot_q, st_q, st_nxt;
  logic [PW:0]     lq_wr, lq_rd, sq_wr, sq_rd;
  logic            trap_ld_q, trap_st_q;
  logic [31:0]     trap_addr_q;

  logic [2:0]      lq_width [MAX_OT];
  logic [OW-1:0]   lq_off   [MAX_OT];
  logic [4:0]      lq_rdst  [MAX_OT];
  logic [31:0]     lq_addr  [MAX_OT];
  logic [31:0]     sq_addr  [MAX_OT];

  logic accept, is_ld, is_st, misalign;
  logic rd_addr_valid, ld_issue, aw_valid, w_valid, aw_hs, w_hs, st_done;
  logic lq_empty, ld_ret, ld_err, st_inc, st_ret, st_err, ot_inc;
  logic [PW-1:0] head;
  logic [OW-1:0] st_off, head_off;
  logic [3:0] st_nb, ld_nb;
  logic [SW-1:0] smask, st_strobe;
  logic [XLEN-1:0] st_bmask, st_data, ld_shift, ld_mask, ld_ext;
  logic ld_sign, ld_sgn;
  logic unused_bits;

  assign accept      = req_valid_i & req_ready_o;
  assign req_ready_o = rst & (state == IDLE) & (ot_q < CW'(MAX_OT));
  assign is_ld       = (req_op_i == 2'b01);
  assign is_st       = (req_op_i == 2'b10);

  assign rd_addr_valid = (state == ISSUE) & ~lat_store;
  assign ld_issue      = rd_addr_valid & data_cb_miso_i.rd_addr_ready;
  assign aw_valid      = (state == ISSUE) & lat_store & ~aw_done;
  assign w_valid       = (state == ISSUE) & lat_store & ~w_done;
  assign aw_hs         = aw_valid & data_cb_miso_i.wr_addr_ready;
  assign w_hs          = w_valid & data_cb_miso_i.wr_data_ready;
  assign st_done       = (state == ISSUE) & lat_store & (aw_done | aw_hs) & (w_done | w_hs);

  assign lq_empty = (lq_wr == lq_rd);
  assign head     = lq_rd[PW-1:0];
  assign ld_ret   = data_cb_miso_i.rd_valid & ~lq_empty;
  assign ld_err   = ld_ret & (data_cb_miso_i.rd_resp != CB_OKAY);

  // Without write responses a store retires as it completes, so it never counts as outstanding.
  assign st_inc = st_done & (SUPPORT_WR_RESP != 0);
  assign st_ret = (SUPPORT_WR_RESP != 0) & data_cb_miso_i.wr_resp_valid & (st_q != '0);
  assign st_err = st_ret & (data_cb_miso_i.wr_resp_error != CB_OKAY);
  assign ot_inc = ld_issue | st_inc;
  assign st_nxt = st_q + CW'(st_inc) - CW'(st_ret);

  assign ot_cnt_o    = ot_q;
  assign trap_ld_o   = trap_ld_q;
  assign trap_st_o   = trap_st_q;
  assign trap_addr_o = trap_addr_q;
  assign unused_bits = ^{data_cb_miso_i.rd_data, lat_width[2]};

  // Flag requests whose address does not match the access size.
  always_comb begin
    misalign = 1'b0;
    case (req_width_i[1:0])
      2'b01:   misalign = req_addr_i[0];
      2'b10:   misalign = (req_addr_i[1:0] != 2'b00);
      2'b11:   misalign = (req_addr_i[2:0] != 3'b000);
      default: misalign = 1'b0;
    endcase
  end

  // Build store strobe and byte-lane data, with unused lanes forced to zero.
  always_comb begin
    st_off   = lat_addr[OW-1:0];
    st_nb    = 4'd1 << lat_width[1:0];
    smask    = '0;
    st_bmask = '0;
    for (int i = 0; i < SW; i++) smask[i] = (4'(i) < st_nb);
    st_strobe = smask << st_off;
    for (int i = 0; i < SW; i++) st_bmask[8*i +: 8] = {8{st_strobe[i]}};
    st_data = (lat_wdata << {st_off, 3'b000}) & st_bmask;
  end

  // Align returning load data to the FIFO head entry and extend it.
  always_comb begin
    head_off = lq_off[head];
    ld_nb    = 4'd1 << lq_width[head][1:0];
    ld_sgn   = ~lq_width[head][2] & (lq_width[head][1:0] != 2'b11);
    ld_shift = data_cb_miso_i.rd_data[XLEN-1:0] >> {head_off, 3'b000};
    ld_mask  = '0;
    ld_sign  = 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (4'(i) < ld_nb) begin
        ld_mask[8*i +: 8] = 8'hFF;
        ld_sign           = ld_shift[8*i + 7];
      end
    end
    ld_ext     = (ld_shift & ld_mask) | ((ld_sgn & ld_sign) ? ~ld_mask : '0);
    ld_valid_o = ld_ret & ~ld_err;
    ld_data_o  = ld_valid_o ? ld_ext : '0;
    ld_rd_o    = ld_valid_o ? lq_rdst[head] : '0;
  end

  // Drive the bus request side from the latched request; ready lines stay high.
  always_comb begin
    data_cb_mosi_o               = '0;
    data_cb_mosi_o.rd_ready      = 1'b1;
    data_cb_mosi_o.wr_resp_ready = 1'b1;
    data_cb_mosi_o.rd_addr_valid = rd_addr_valid;
    data_cb_mosi_o.rd_addr       = {lat_addr[31:OW], {OW{1'b0}}};
    data_cb_mosi_o.rd_size       = 3'(OW);
    data_cb_mosi_o.wr_addr_valid = aw_valid;
    data_cb_mosi_o.wr_addr       = {lat_addr[31:OW], {OW{1'b0}}};
    data_cb_mosi_o.wr_size       = {1'b0, lat_width[1:0]};
    data_cb_mosi_o.wr_data_valid = w_valid;
    data_cb_mosi_o.wr_data       = 64'(st_data);
    data_cb_mosi_o.wr_strobe     = 8'(st_strobe);
  end

  // Metadata storage for issued loads and outstanding stores; no reset needed.
  always_ff @(posedge clk) begin
    if (ld_issue) begin
      lq_width[lq_wr[PW-1:0]] <= lat_width;
      lq_off[lq_wr[PW-1:0]]   <= lat_addr[OW-1:0];
      lq_rdst[lq_wr[PW-1:0]]  <= lat_rd;
      lq_addr[lq_wr[PW-1:0]]  <= lat_addr;
    end
    if (st_inc) sq_addr[sq_wr[PW-1:0]] <= lat_addr;
  end

  // Control FSM, counters, FIFO pointers and trap pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lat_store   <= 1'b0;
      lat_width   <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_rd      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ot_q        <= '0;
      st_q        <= '0;
      lq_wr       <= '0;
      lq_rd       <= '0;
      sq_wr       <= '0;
      sq_rd       <= '0;
      trap_ld_q   <= 1'b0;
      trap_st_q   <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      ot_q      <= ot_q + CW'(ot_inc) - CW'(ld_ret) - CW'(st_ret);
      st_q      <= st_nxt;
      trap_ld_q <= 1'b0;
      trap_st_q <= 1'b0;
      if (ld_issue) lq_wr <= lq_wr + 1'b1;
      if (ld_ret)   lq_rd <= lq_rd + 1'b1;
      if (st_inc)   sq_wr <= sq_wr + 1'b1;
      if (st_ret)   sq_rd <= sq_rd + 1'b1;
      if (st_err) begin
        trap_st_q   <= 1'b1;
        trap_addr_q <= sq_addr[sq_rd[PW-1:0]];
      end
      if (ld_err) begin
        trap_ld_q   <= 1'b1;
        trap_addr_q <= lq_addr[head];
      end
      if (accept && (is_ld || is_st) && misalign) begin
        if (is_ld) trap_ld_q <= 1'b1;
        else       trap_st_q <= 1'b1;
        trap_addr_q <= req_addr_i;
      end
      case (state)
        IDLE: begin
          if (accept && (is_ld || is_st) && !misalign) begin
            lat_store <= is_st;
            lat_width <= req_width_i;
            lat_addr  <= req_addr_i;
            lat_wdata <= req_wdata_i;
            lat_rd    <= req_rd_i;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= (is_ld && st_q != '0) ? HOLD : ISSUE;
          end
        end
        HOLD: begin
          if (st_nxt == '0) state <= ISSUE;
        end
        ISSUE: begin
          if (lat_store) begin
            if (st_done) begin
              state   <= IDLE;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              aw_done <= aw_done | aw_hs;
              w_done  <= w_done | w_hs;
            end
          end else if (ld_issue) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_nb.sv
// Directed bench for lsu_nb: each task drives one scenario and checks its own results.

module tb_lsu_nb;
  import lsu_nb_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd;
  s_cb_mosi_t  mosi;
  s_cb_miso_t  miso;
  logic        trap_ld;
  logic        trap_st;
  logic [31:0] trap_addr;
  logic [2:0]  ot_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int bench_lds;

  lsu_nb #(.XLEN(32), .MAX_OT(4), .SUPPORT_WR_RESP(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_width_i    (req_width),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_rd_i       (req_rd),
    .ld_valid_o     (ld_valid),
    .ld_data_o      (ld_data),
    .ld_rd_o        (ld_rd),
    .data_cb_mosi_o (mosi),
    .data_cb_miso_i (miso),
    .trap_ld_o      (trap_ld),
    .trap_st_o      (trap_st),
    .trap_addr_o    (trap_addr),
    .ot_cnt_o       (ot_cnt)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A read response is only legal while the bench has seen at least one unreturned load issue.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bench_lds <= 0;
    end else begin
      if (miso.rd_valid) assert (bench_lds > 0) else $error("[TB] rd_valid with no load outstanding");
      bench_lds <= bench_lds + ((mosi.rd_addr_valid && miso.rd_addr_ready) ? 1 : 0) - (miso.rd_valid ? 1 : 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it for exactly one accepting edge.
  task automatic send_req(input logic [1:0] op, input logic [2:0] width, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      total_cnt++;
      $display("[TB] FAIL req_ready_timeout got=%0b exp=1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_width = width;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    total_cnt++; if (req_ready !== 1'b0) $display("[TB] FAIL rst_req_ready got=%0b exp=0", req_ready); else pass_cnt++;
    total_cnt++; if ({mosi.rd_addr_valid, mosi.wr_addr_valid, mosi.wr_data_valid} !== 3'b000)
      $display("[TB] FAIL rst_valids got=%b exp=000", {mosi.rd_addr_valid, mosi.wr_addr_valid, mosi.wr_data_valid}); else pass_cnt++;
    total_cnt++; if ({ld_valid, trap_ld, trap_st, ot_cnt} !== 6'd0)
      $display("[TB] FAIL rst_outputs got=%b exp=0", {ld_valid, trap_ld, trap_st, ot_cnt}); else pass_cnt++;
    total_cnt++; if ({mosi.rd_ready, mosi.wr_resp_ready} !== 2'b11)
      $display("[TB] FAIL rst_bus_ready got=%b exp=11", {mosi.rd_ready, mosi.wr_resp_ready}); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if (req_ready !== 1'b1) $display("[TB] FAIL idle_req_ready got=%0b exp=1", req_ready); else pass_cnt++;
  endtask

  task automatic test_lw;
    send_req(2'b01, 3'b010, 32'h100, 32'h0, 5'd5);
    total_cnt++; if (mosi.rd_addr_valid !== 1'b1) $display("[TB] FAIL lw_rd_addr_valid got=%0b exp=1", mosi.rd_addr_valid); else pass_cnt++;
    total_cnt++; if (mosi.rd_addr !== 32'h100) $display("[TB] FAIL lw_rd_addr got=%h exp=00000100", mosi.rd_addr); else pass_cnt++;
    tick();
    total_cnt++; if (ot_cnt !== 3'd1) $display("[TB] FAIL lw_ot_after_issue got=%0d exp=1", ot_cnt); else pass_cnt++;
    tick();
    tick();
    miso.rd_valid = 1'b1;
    miso.rd_data  = 64'h0000_0000_DEAD_BEEF;
    #1;
    total_cnt++; if (ld_valid !== 1'b1) $display("[TB] FAIL lw_ld_valid got=%0b exp=1", ld_valid); else pass_cnt++;
    total_cnt++; if (ld_data !== 32'hDEADBEEF) $display("[TB] FAIL lw_ld_data got=%h exp=deadbeef", ld_data); else pass_cnt++;
    total_cnt++; if (ld_rd !== 5'd5) $display("[TB] FAIL lw_ld_rd got=%0d exp=5", ld_rd); else pass_cnt++;
    tick();
    miso.rd_valid = 1'b0;
    #1;
    total_cnt++; if ({ld_valid, ot_cnt} !== 4'b0000) $display("[TB] FAIL lw_after_return got=%b exp=0000", {ld_valid, ot_cnt}); else pass_cnt++;
  endtask

  task automatic test_lb_lbu;
    logic [2:0]  widths [2] = '{3'b000, 3'b100};
    logic [31:0] exps   [2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int i = 0; i < 2; i++) begin
      send_req(2'b01, widths[i], 32'h103, 32'h0, 5'd6);
      total_cnt++; if (mosi.rd_addr !== 32'h100) $display("[TB] FAIL lb_aligned_addr[%0d] got=%h exp=00000100", i, mosi.rd_addr); else pass_cnt++;
      tick();
      miso.rd_valid = 1'b1;
      miso.rd_data  = 64'h0000_0000_80FF_FFFF;
      #1;
      total_cnt++; if (ld_data !== exps[i]) $display("[TB] FAIL lb_data[%0d] got=%h exp=%h", i, ld_data, exps[i]); else pass_cnt++;
      tick();
      miso.rd_valid = 1'b0;
    end
  endtask

  task automatic test_sh;
    miso.wr_addr_ready = 1'b0;
    send_req(2'b10, 3'b001, 32'h102, 32'h0000_1234, 5'd0);
    total_cnt++; if ({mosi.wr_addr_valid, mosi.wr_data_valid} !== 2'b11)
      $display("[TB] FAIL sh_valids got=%b exp=11", {mosi.wr_addr_valid, mosi.wr_data_valid}); else pass_cnt++;
    total_cnt++; if (mosi.wr_strobe[3:0] !== 4'b1100) $display("[TB] FAIL sh_strobe got=%b exp=1100", mosi.wr_strobe[3:0]); else pass_cnt++;
    total_cnt++; if (mosi.wr_data[31:0] !== 32'h1234_0000) $display("[TB] FAIL sh_data got=%h exp=12340000", mosi.wr_data[31:0]); else pass_cnt++;
    tick();
    total_cnt++; if ({mosi.wr_addr_valid, mosi.wr_data_valid} !== 2'b10)
      $display("[TB] FAIL sh_split_valids got=%b exp=10", {mosi.wr_addr_valid, mosi.wr_data_valid}); else pass_cnt++;
    miso.wr_addr_ready = 1'b1;
    tick();
    total_cnt++; if ({mosi.wr_addr_valid, mosi.wr_data_valid} !== 2'b00)
      $display("[TB] FAIL sh_done_valids got=%b exp=00", {mosi.wr_addr_valid, mosi.wr_data_valid}); else pass_cnt++;
    total_cnt++; if (ot_cnt !== 3'd1) $display("[TB] FAIL sh_ot got=%0d exp=1", ot_cnt); else pass_cnt++;
    miso.wr_resp_valid = 1'b1;
    tick();
    miso.wr_resp_valid = 1'b0;
    #1;
    total_cnt++; if ({ot_cnt, trap_st} !== 4'b0000) $display("[TB] FAIL sh_retire got=%b exp=0000", {ot_cnt, trap_st}); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    for (int k = 1; k <= 4; k++) send_req(2'b01, 3'b010, 32'h200 + 32'(4 * (k - 1)), 32'h0, 5'(k));
    tick();
    total_cnt++; if (ot_cnt !== 3'd4) $display("[TB] FAIL b2b_ot_full got=%0d exp=4", ot_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("[TB] FAIL b2b_req_ready got=%0b exp=0", req_ready); else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      miso.rd_valid = 1'b1;
      miso.rd_data  = 64'(32'h1111_1111 * k);
      #1;
      total_cnt++; if ({ld_valid, ld_rd} !== {1'b1, 5'(k)}) $display("[TB] FAIL b2b_order[%0d] got=%0d exp=%0d", k, ld_rd, k); else pass_cnt++;
      total_cnt++; if (ld_data !== 32'h1111_1111 * k) $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", k, ld_data, 32'h1111_1111 * k); else pass_cnt++;
      tick();
      if (k == 1) begin
        total_cnt++; if (ot_cnt !== 3'd3) $display("[TB] FAIL b2b_ot_after_first got=%0d exp=3", ot_cnt); else pass_cnt++;
      end
    end
    miso.rd_valid = 1'b0;
    #1;
    total_cnt++; if (ot_cnt !== 3'd0) $display("[TB] FAIL b2b_ot_drained got=%0d exp=0", ot_cnt); else pass_cnt++;
  endtask

  task automatic test_store_load_order;
    logic early = 1'b0;
    send_req(2'b10, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd0);
    tick();
    send_req(2'b01, 3'b010, 32'h304, 32'h0, 5'd7);
    for (int i = 0; i < 5; i++) begin
      if (mosi.rd_addr_valid) early = 1'b1;
      tick();
    end
    miso.wr_resp_valid = 1'b1;
    #1;
    if (mosi.rd_addr_valid) early = 1'b1;
    total_cnt++; if (early !== 1'b0) $display("[TB] FAIL order_load_passed_store got=%0b exp=0", early); else pass_cnt++;
    tick();
    miso.wr_resp_valid = 1'b0;
    #1;
    total_cnt++; if (mosi.rd_addr_valid !== 1'b1) $display("[TB] FAIL order_load_issue got=%0b exp=1", mosi.rd_addr_valid); else pass_cnt++;
    total_cnt++; if (mosi.rd_addr !== 32'h304) $display("[TB] FAIL order_load_addr got=%h exp=00000304", mosi.rd_addr); else pass_cnt++;
    tick();
    miso.rd_valid = 1'b1;
    miso.rd_data  = 64'h0000_0000_0000_0042;
    #1;
    total_cnt++; if ({ld_valid, ld_rd} !== {1'b1, 5'd7}) $display("[TB] FAIL order_load_return got=%b exp=1_00111", {ld_valid, ld_rd}); else pass_cnt++;
    tick();
    miso.rd_valid = 1'b0;
  endtask

  task automatic test_traps;
    send_req(2'b01, 3'b010, 32'h101, 32'h0, 5'd3);
    total_cnt++; if (trap_ld !== 1'b1) $display("[TB] FAIL mis_ld_trap got=%0b exp=1", trap_ld); else pass_cnt++;
    total_cnt++; if (trap_addr !== 32'h101) $display("[TB] FAIL mis_ld_addr got=%h exp=00000101", trap_addr); else pass_cnt++;
    total_cnt++; if ({mosi.rd_addr_valid, ot_cnt} !== 4'b0000) $display("[TB] FAIL mis_ld_no_bus got=%b exp=0000", {mosi.rd_addr_valid, ot_cnt}); else pass_cnt++;
    tick();
    total_cnt++; if (trap_ld !== 1'b0) $display("[TB] FAIL mis_ld_pulse got=%0b exp=0", trap_ld); else pass_cnt++;
    send_req(2'b10, 3'b001, 32'h103, 32'hFFFF, 5'd0);
    total_cnt++; if ({trap_st, mosi.wr_addr_valid} !== 2'b10) $display("[TB] FAIL mis_st got=%b exp=10", {trap_st, mosi.wr_addr_valid}); else pass_cnt++;
    total_cnt++; if (trap_addr !== 32'h103) $display("[TB] FAIL mis_st_addr got=%h exp=00000103", trap_addr); else pass_cnt++;
    send_req(2'b00, 3'b010, 32'h800, 32'h0, 5'd1);
    total_cnt++; if ({mosi.rd_addr_valid, mosi.wr_addr_valid, ot_cnt} !== 5'd0)
      $display("[TB] FAIL noop_ignored got=%b exp=00000", {mosi.rd_addr_valid, mosi.wr_addr_valid, ot_cnt}); else pass_cnt++;
    send_req(2'b01, 3'b010, 32'h500, 32'h0, 5'd9);
    tick();
    miso.rd_valid = 1'b1;
    miso.rd_resp  = 2'b10;
    miso.rd_data  = 64'h1234;
    #1;
    total_cnt++; if (ld_valid !== 1'b0) $display("[TB] FAIL buserr_ld_valid got=%0b exp=0", ld_valid); else pass_cnt++;
    tick();
    miso.rd_valid = 1'b0;
    miso.rd_resp  = 2'b00;
    #1;
    total_cnt++; if ({trap_ld, trap_addr} !== {1'b1, 32'h500}) $display("[TB] FAIL buserr_trap got=%b_%h exp=1_00000500", trap_ld, trap_addr); else pass_cnt++;
    total_cnt++; if (ot_cnt !== 3'd0) $display("[TB] FAIL buserr_ot got=%0d exp=0", ot_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_issue;
    send_req(2'b01, 3'b010, 32'h700, 32'h0, 5'd2);
    tick();
    miso.rd_addr_ready = 1'b0;
    send_req(2'b01, 3'b010, 32'h600, 32'h0, 5'd4);
    total_cnt++; if ({mosi.rd_addr_valid, ot_cnt} !== 4'b1001) $display("[TB] FAIL mid_issue_pre got=%b exp=1001", {mosi.rd_addr_valid, ot_cnt}); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if ({mosi.rd_addr_valid, mosi.wr_addr_valid, mosi.wr_data_valid, ot_cnt} !== 6'd0)
      $display("[TB] FAIL mid_issue_reset got=%b exp=000000", {mosi.rd_addr_valid, mosi.wr_addr_valid, mosi.wr_data_valid, ot_cnt}); else pass_cnt++;
    total_cnt++; if ({req_ready, mosi.rd_ready, mosi.wr_resp_ready} !== 3'b011)
      $display("[TB] FAIL mid_issue_ready got=%b exp=011", {req_ready, mosi.rd_ready, mosi.wr_resp_ready}); else pass_cnt++;
    miso.rd_addr_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    total_cnt++; if (req_ready !== 1'b1) $display("[TB] FAIL post_reset_ready got=%0b exp=1", req_ready); else pass_cnt++;
  endtask

  // Overall time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Scenario sequence.
  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_width = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    req_rd    = '0;
    miso      = '0;
    miso.rd_addr_ready = 1'b1;
    miso.wr_addr_ready = 1'b1;
    miso.wr_data_ready = 1'b1;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_back_to_back();
    test_store_load_order();
    test_traps();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
